// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: stereo PDM mic clocking, channel split, CIC sequencing and frame FIFO
module pdm_mic_ctrl #(
    parameter int CLK_DIV            = 16,
    parameter int STARTUP_PDM_CYCLES = 1024,
    parameter int SETTLE_FRAMES      = 3,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        pdm_clk_o,
    input  logic        pdm_data_i,
    output logic        cic_rst,
    output logic        pdm_l,
    output logic        ce_l,
    output logic        pdm_r,
    output logic        ce_r,
    input  logic [15:0] pcm_l,
    input  logic        pcm_l_valid,
    input  logic [15:0] pcm_r,
    input  logic        pcm_r_valid,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        overflow,
    output logic        desync,
    input  logic        clear_flags,
    output logic        running
);
    localparam int DW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;
    localparam int WW   = $clog2(STARTUP_PDM_CYCLES + 1);
    localparam int SW   = $clog2(SETTLE_FRAMES + 2);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt, div_nx;
    logic [WW-1:0] wrap_cnt;
    logic [SW-1:0] settle_cnt;
    logic          pdm_s1, pdm_s2;
    logic          wrap, run_en, lv, rv, form, settled, dsync_set, push;
    logic [15:0]   hold_l, hold_r;
    logic          have_l, have_r;
    logic [31:0]   frame_nx, frame_reg;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, wr_ok, ovf_set;

    assign wrap    = div_cnt == DW'(CLK_DIV - 1);
    assign run_en  = state == RUN && enable;
    assign lv      = run_en && pcm_l_valid;
    assign rv      = run_en && pcm_r_valid;
    assign settled = settle_cnt == SW'(SETTLE_FRAMES);

    // next state and divider; disable always wins and parks the divider at 0
    always_comb begin
        state_nx  = !enable ? IDLE :
                    state == IDLE ? WARMUP :
                    (state == WARMUP && wrap && wrap_cnt == WW'(STARTUP_PDM_CYCLES - 1)) ? RUN : state;
        div_nx    = (state == IDLE || state_nx == IDLE || wrap) ? '0 : div_cnt + 1'b1;
        form      = (lv && rv) || (lv && !have_l && have_r) || (rv && !have_r && have_l);
        frame_nx  = {lv ? pcm_l : hold_l, rv ? pcm_r : hold_r};
        dsync_set = (lv && have_l) || (rv && have_r);
    end

    // input synchronizer, FSM, warm-up counter and registered clock/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_s1    <= 1'b0;
            pdm_s2    <= 1'b0;
            state     <= IDLE;
            div_cnt   <= '0;
            wrap_cnt  <= '0;
            pdm_clk_o <= 1'b0;
            cic_rst   <= 1'b1;
            running   <= 1'b0;
        end else begin
            pdm_s1    <= pdm_data_i;
            pdm_s2    <= pdm_s1;
            state     <= state_nx;
            div_cnt   <= div_nx;
            wrap_cnt  <= state_nx != WARMUP ? '0 : (state == WARMUP && wrap) ? wrap_cnt + 1'b1 : wrap_cnt;
            pdm_clk_o <= state_nx != IDLE && div_nx >= DW'(HALF);
            cic_rst   <= state_nx != RUN;
            running   <= state_nx == RUN;
        end
    end

    // right bit sampled at the end of the low phase, left at the end of the high phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_l <= 1'b0;
            pdm_r <= 1'b0;
            ce_l  <= 1'b0;
            ce_r  <= 1'b0;
        end else begin
            ce_r <= run_en && div_cnt == DW'(HALF - 1);
            ce_l <= run_en && wrap;
            if (run_en && div_cnt == DW'(HALF - 1))
                pdm_r <= pdm_s2;
            if (run_en && wrap)
                pdm_l <= pdm_s2;
        end
    end

    // pair left/right samples into frames and drop the first frames while the CICs settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_l     <= '0;
            hold_r     <= '0;
            have_l     <= 1'b0;
            have_r     <= 1'b0;
            frame_reg  <= '0;
            push       <= 1'b0;
            settle_cnt <= '0;
        end else begin
            if (lv)
                hold_l <= pcm_l;
            if (rv)
                hold_r <= pcm_r;
            have_l     <= run_en && !form && (have_l || lv);
            have_r     <= run_en && !form && (have_r || rv);
            if (form)
                frame_reg <= frame_nx;
            push       <= form && settled;
            settle_cnt <= !run_en ? '0 : (form && !settled) ? settle_cnt + 1'b1 : settle_cnt;
        end
    end

    assign pop         = frame_valid && frame_ready;
    assign full        = count == (AW + 1)'(FIFO_DEPTH);
    assign wr_ok       = push && (!full || pop);
    assign ovf_set     = push && full && !pop;
    assign frame_valid = count != '0;
    assign frame_data  = mem[rd_ptr];

    // FIFO pointers, occupancy and sticky error flags (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            desync   <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr_ok);
            rd_ptr   <= rd_ptr + AW'(pop);
            count    <= count + (AW + 1)'(wr_ok) - (AW + 1)'(pop);
            overflow <= ovf_set || (overflow && !clear_flags);
            desync   <= dsync_set || (desync && !clear_flags);
        end
    end

    // frame storage
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= frame_reg;
    end
endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// tb_pdm_mic_ctrl: directed table and sequence checks for pdm_mic_ctrl
module tb_pdm_mic_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pdm_clk_o;
    logic        pdm_data_i = 1'b0;
    logic        cic_rst, pdm_l, ce_l, pdm_r, ce_r;
    logic [15:0] pcm_l = '0;
    logic        pcm_l_valid = 1'b0;
    logic [15:0] pcm_r = '0;
    logic        pcm_r_valid = 1'b0;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        overflow, desync;
    logic        clear_flags = 1'b0;
    logic        running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          mode;
        logic [15:0] l;
        logic [15:0] r;
        logic        ev;
        logic [31:0] eh;
        logic        eo;
        logic        ed;
    } vec_t;

    vec_t tbl [9];

    pdm_mic_ctrl #(
        .CLK_DIV(8),
        .STARTUP_PDM_CYCLES(4),
        .SETTLE_FRAMES(3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .pdm_clk_o(pdm_clk_o),
        .pdm_data_i(pdm_data_i),
        .cic_rst(cic_rst),
        .pdm_l(pdm_l),
        .ce_l(ce_l),
        .pdm_r(pdm_r),
        .ce_r(ce_r),
        .pcm_l(pcm_l),
        .pcm_l_valid(pcm_l_valid),
        .pcm_r(pcm_r),
        .pcm_r_valid(pcm_r_valid),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overflow(overflow),
        .desync(desync),
        .clear_flags(clear_flags),
        .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // data high during the low phase, low during the high phase
    initial begin
        forever begin
            @(negedge clk);
            pdm_data_i = ~pdm_clk_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input int mode, input logic [15:0] l, input logic [15:0] l2, input logic [15:0] r);
        @(negedge clk);
        pcm_l = l;
        pcm_l_valid = 1'b1;
        if (mode == 1) begin
            pcm_r = r;
            pcm_r_valid = 1'b1;
        end else if (mode == 2) begin
            @(negedge clk);
            pcm_l = l2;
        end
        @(negedge clk);
        pcm_l_valid = 1'b0;
        if (mode != 1) begin
            pcm_r = r;
            pcm_r_valid = 1'b1;
            @(negedge clk);
        end
        pcm_r_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic startup();
        int first = -1;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (first < 0) begin
                chk("pdm_clk_phase", pdm_clk_o, (k % 8) >= 4);
                chk("cic_rst_warmup", cic_rst, k < 32);
                chk("running_warmup", running, k >= 32);
                chk("ce_l_early", ce_l, 1'b0);
            end
            if (ce_r && first < 0)
                first = k;
        end
        chk("first_ce_r_latency", first, 36);
    endtask

    initial begin
        int nr, nl;
        logic [31:0] exp_q [4];
        tbl[0] = '{0, 16'h1234, 16'hABCD, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{0, 16'h1234, 16'hABCD, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[2] = '{0, 16'h1234, 16'hABCD, 1'b0, 32'h0,        1'b0, 1'b0};
        tbl[3] = '{0, 16'h1234, 16'hABCD, 1'b1, 32'h1234ABCD, 1'b0, 1'b0};
        tbl[4] = '{0, 16'h1234, 16'hABCD, 1'b1, 32'h1234ABCD, 1'b0, 1'b0};
        tbl[5] = '{0, 16'h1111, 16'h2222, 1'b1, 32'h1234ABCD, 1'b0, 1'b0};
        tbl[6] = '{1, 16'h3333, 16'h4444, 1'b1, 32'h1234ABCD, 1'b0, 1'b0};
        tbl[7] = '{0, 16'h5555, 16'h6666, 1'b1, 32'h1234ABCD, 1'b1, 1'b0};
        tbl[8] = '{0, 16'h7777, 16'h8888, 1'b1, 32'h1234ABCD, 1'b1, 1'b0};
        exp_q = '{32'h1234ABCD, 32'h11112222, 32'h33334444, 32'h9999AAAA};

        repeat (3) @(negedge clk);
        chk("rst_running", running, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_desync", desync, 1'b0);
        chk("rst_cic_rst", cic_rst, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_pdm_clk", pdm_clk_o, 1'b0);
            chk("idle_cic_rst", cic_rst, 1'b1);
            chk("idle_ce", {ce_l, ce_r}, 2'b00);
            chk("idle_frame_valid", frame_valid, 1'b0);
        end

        startup();

        nr = 0;
        nl = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ce_r) begin
                nr++;
                chk("pdm_r_bit", pdm_r, 1'b1);
            end
            if (ce_l) begin
                nl++;
                chk("pdm_l_bit", pdm_l, 1'b0);
            end
        end
        chk("ce_r_count", nr, 10);
        chk("ce_l_count", nl, 10);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].mode, tbl[i].l, tbl[i].l, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), frame_valid, tbl[i].ev);
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_head", i), frame_data, tbl[i].eh);
            chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].eo);
            chk($sformatf("tbl%0d_desync", i), desync, tbl[i].ed);
        end

        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        pcm_l = 16'h9999;
        pcm_r = 16'hAAAA;
        pcm_l_valid = 1'b1;
        pcm_r_valid = 1'b1;
        @(negedge clk);
        pcm_l_valid = 1'b0;
        pcm_r_valid = 1'b0;
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        @(negedge clk);
        chk("full_pushpop_ovf", overflow, 1'b0);
        chk("full_pushpop_head", frame_data, 32'h1234ABCD);

        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), frame_valid, 1'b1);
            chk($sformatf("drain%0d_head", i), frame_data, exp_q[i]);
            @(negedge clk);
        end
        chk("drain_empty", frame_valid, 1'b0);
        frame_ready = 1'b0;

        send(2, 16'h0001, 16'h0002, 16'h0003);
        chk("desync_set", desync, 1'b1);
        chk("desync_valid", frame_valid, 1'b1);
        chk("desync_head", frame_data, 32'h00020003);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        chk("desync_cleared", desync, 1'b0);
        chk("desync_popped", frame_valid, 1'b0);

        pcm_l = 16'h5A5A;
        pcm_r = 16'hA5A5;
        pcm_l_valid = 1'b1;
        pcm_r_valid = 1'b1;
        @(negedge clk);
        pcm_l_valid = 1'b0;
        pcm_r_valid = 1'b0;
        chk("latency_c1", frame_valid, 1'b0);
        @(negedge clk);
        chk("latency_c2", frame_valid, 1'b1);
        chk("latency_head", frame_data, 32'h5A5AA5A5);

        pcm_l = 16'h7E7E;
        pcm_l_valid = 1'b1;
        @(negedge clk);
        pcm_l_valid = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk("dis_running", running, 1'b0);
        chk("dis_pdm_clk", pdm_clk_o, 1'b0);
        chk("dis_cic_rst", cic_rst, 1'b1);
        for (int i = 0; i < 20; i++) begin
            pcm_r = 16'h0BAD;
            pcm_r_valid = (i % 4) == 0;
            @(negedge clk);
            chk("dis_quiet", {ce_l, ce_r, pdm_clk_o}, 3'b000);
        end
        pcm_r_valid = 1'b0;
        chk("dis_head", frame_data, 32'h5A5AA5A5);
        chk("dis_valid", frame_valid, 1'b1);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        chk("dis_drained", frame_valid, 1'b0);

        startup();
        for (int i = 0; i < 4; i++) begin
            send(0, 16'h0C0C, 16'h0C0C, 16'h0D0D);
            chk($sformatf("resettle%0d_valid", i), frame_valid, i == 3);
        end
        chk("resettle_desync", desync, 1'b0);
        chk("resettle_head", frame_data, 32'h0C0C0D0D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
